wts_i2s_out: RTL and testbench



---
 rtl/wts_i2s_out.sv | 138 +++++++++++++
 tb/tb_wts_i2s_out.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wts_i2s_out.sv
// ---------------------------------------------------------------------------
// wts_i2s_out
//
// Stereo serial audio transmitter for the wave table sound core. The 12-bit
// left/right mix samples are widened to 16 bits (in12 << 4, sign preserved)
// and shifted out MSB first as a continuous 32-slot frame (16 left, 16 right).
// Bit clock and word select are derived from clk; one new sample pair is
// captured per frame.
//
// Build option:
//   WTS_I2S_LJ_EN  defined   -> left-justified: data bit leaves in the same
//                               slot as its lrclk edge (no delay flop).
//                  undefined -> standard I2S: data lags lrclk by one bclk.
//
// Parameters:
//   CLK_DIV      clk cycles per bclk half-period (1..255)
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous, active-high reset
//   enable       1 = run, 0 = idle (frame abandoned, state cleared)
//   left_in      left sample, two's complement, read only at frame capture
//   right_in     right sample, two's complement, read only at frame capture
//   i2s_bclk     bit clock
//   i2s_lrclk    word select, 0 = left slot, 1 = right slot
//   i2s_sdata    serial data, MSB first, changes with bclk falling
//   frame_start  one-clk pulse on each sample capture
// ---------------------------------------------------------------------------
module wts_i2s_out #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [11:0] left_in,
  input  logic [11:0] right_in,
  output logic        i2s_bclk,
  output logic        i2s_lrclk,
  output logic        i2s_sdata,
  output logic        frame_start
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  logic [7:0]  div_q,   div_d;
  logic        bclk_q,  bclk_d;
  logic [4:0]  slot_q,  slot_d;
  logic        lrclk_q, lrclk_d;
  logic        sdata_q, sdata_d;
  logic        fs_q,    fs_d;
  logic [31:0] shreg_q, shreg_d;
`ifndef WTS_I2S_LJ_EN
  logic        dly_q,   dly_d;
`endif
  logic        word_bit;

  always_comb begin
    div_d    = div_q;
    bclk_d   = bclk_q;
    slot_d   = slot_q;
    lrclk_d  = lrclk_q;
    sdata_d  = sdata_q;
    fs_d     = 1'b0;
    shreg_d  = shreg_q;
`ifndef WTS_I2S_LJ_EN
    dly_d    = dly_q;
`endif
    word_bit = 1'b0;

    if (!enable) begin
      // Idle has priority over everything, including a capture on this edge.
      div_d   = '0;
      bclk_d  = 1'b0;
      slot_d  = 5'd31;
      lrclk_d = 1'b0;
      sdata_d = 1'b0;
      shreg_d = '0;
`ifndef WTS_I2S_LJ_EN
      dly_d   = 1'b0;
`endif
    end else if (div_q == DIV_LAST) begin
      div_d  = '0;
      bclk_d = ~bclk_q;
      if (bclk_q) begin
        // Falling toggle: advance slot, capture on the 31 -> 0 wrap.
        slot_d = slot_q + 5'd1;
        if (slot_q == 5'd31) begin
          shreg_d = {left_in, 4'h0, right_in, 4'h0};
          fs_d    = 1'b1;
        end
        lrclk_d = slot_d[4];
        // Word bit for slot s is bit (31 - s); ~s is the same in 5 bits.
        // Uses shreg_d so slot 0 sees the word captured on this very edge.
        word_bit = shreg_d[~slot_d];
`ifdef WTS_I2S_LJ_EN
        sdata_d = word_bit;
`else
        sdata_d = dly_q;
        dly_d   = word_bit;
`endif
      end
    end else begin
      div_d = div_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q   <= '0;
      bclk_q  <= 1'b0;
      slot_q  <= 5'd31;
      lrclk_q <= 1'b0;
      sdata_q <= 1'b0;
      fs_q    <= 1'b0;
      shreg_q <= '0;
`ifndef WTS_I2S_LJ_EN
      dly_q   <= 1'b0;
`endif
    end else begin
      div_q   <= div_d;
      bclk_q  <= bclk_d;
      slot_q  <= slot_d;
      lrclk_q <= lrclk_d;
      sdata_q <= sdata_d;
      fs_q    <= fs_d;
      shreg_q <= shreg_d;
`ifndef WTS_I2S_LJ_EN
      dly_q   <= dly_d;
`endif
    end
  end

  assign i2s_bclk    = bclk_q;
  assign i2s_lrclk   = lrclk_q;
  assign i2s_sdata   = sdata_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_wts_i2s_out.sv
// ---------------------------------------------------------------------------
// Bench for wts_i2s_out. Two instances (CLK_DIV = 2 and CLK_DIV = 1) share
// one stimulus stream. Expected outputs come from closed-form timing:
// cycles since enable give bclk phase, slot and frame; the captured word per
// frame is recorded when the bench knows capture happens. Instance A's
// serial stream is also decoded back into 32-bit words for directed checks.
// ---------------------------------------------------------------------------
module tb_wts_i2s_out;

  localparam int CD_A = 2;
  localparam int CD_B = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [11:0] left_in;
  logic [11:0] right_in;
  logic        bclk_a, lr_a, sd_a, fs_a;
  logic        bclk_b, lr_b, sd_b, fs_b;

  wts_i2s_out #(.CLK_DIV(CD_A)) u_dut_a (
    .clk(clk), .reset(reset), .enable(enable),
    .left_in(left_in), .right_in(right_in),
    .i2s_bclk(bclk_a), .i2s_lrclk(lr_a), .i2s_sdata(sd_a),
    .frame_start(fs_a)
  );

  wts_i2s_out #(.CLK_DIV(CD_B)) u_dut_b (
    .clk(clk), .reset(reset), .enable(enable),
    .left_in(left_in), .right_in(right_in),
    .i2s_bclk(bclk_b), .i2s_lrclk(lr_b), .i2s_sdata(sd_b),
    .frame_start(fs_b)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference state per instance: cycles since run start, current and
  // previous frame words.
  int          t    [2];
  logic [31:0] cur  [2];
  logic [31:0] prev [2];
  int          cdv  [2];

  logic [31:0] rx_sr   = '0;
  logic [31:0] rx_word = '0;
  int          rx_cnt  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit is_cap(input int cd, input int tt);
    return (tt >= 2*cd) && (((tt - 2*cd) % (64*cd)) == 0);
  endfunction

  // {bclk, lrclk, sdata, frame_start}
  function automatic logic [3:0] expect_out(input int i);
    int cd = cdv[i];
    int tt = t[i];
    int k, s;
    logic b, l, d, f;
    b = ((tt / cd) % 2) == 1;
    k = tt / (2*cd);
    l = 1'b0;
    d = 1'b0;
    if (k > 0) begin
      s = (k - 1) % 32;
      l = (s >= 16);
`ifdef WTS_I2S_LJ_EN
      d = cur[i][31 - s];
`else
      d = (s == 0) ? prev[i][0] : cur[i][32 - s];
`endif
    end
    f = is_cap(cd, tt);
    return {b, l, d, f};
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, ".a.bclk"}, 32'(bclk_a), 32'd0);
    check({tag, ".a.lr"},   32'(lr_a),   32'd0);
    check({tag, ".a.sd"},   32'(sd_a),   32'd0);
    check({tag, ".a.fs"},   32'(fs_a),   32'd0);
    check({tag, ".b.bclk"}, 32'(bclk_b), 32'd0);
    check({tag, ".b.lr"},   32'(lr_b),   32'd0);
    check({tag, ".b.sd"},   32'(sd_b),   32'd0);
    check({tag, ".b.fs"},   32'(fs_b),   32'd0);
  endtask

  // One clk edge: advance the reference, compare every output of both DUTs,
  // and feed instance A's data into the serial decoder.
  task automatic step();
    logic [31:0] w;
    logic [3:0]  e, o;
    int          j, s;
    @(posedge clk);
    #1;
    w = {left_in, 4'h0, right_in, 4'h0};
    for (int i = 0; i < 2; i++) begin
      if (reset || !enable) begin
        t[i] = 0; cur[i] = '0; prev[i] = '0;
      end else begin
        t[i]++;
        if (is_cap(cdv[i], t[i])) begin
          prev[i] = cur[i];
          cur[i]  = w;
        end
      end
    end
    for (int i = 0; i < 2; i++) begin
      e = expect_out(i);
      o = (i == 0) ? {bclk_a, lr_a, sd_a, fs_a} : {bclk_b, lr_b, sd_b, fs_b};
      check($sformatf("%s.bclk t=%0d", i == 0 ? "a" : "b", t[i]), 32'(o[3]), 32'(e[3]));
      check($sformatf("%s.lrclk t=%0d", i == 0 ? "a" : "b", t[i]), 32'(o[2]), 32'(e[2]));
      check($sformatf("%s.sdata t=%0d", i == 0 ? "a" : "b", t[i]), 32'(o[1]), 32'(e[1]));
      check($sformatf("%s.fs t=%0d", i == 0 ? "a" : "b", t[i]), 32'(o[0]), 32'(e[0]));
    end
    // Receiver view: sample sdata at each bclk rise of instance A.
    if (t[0] >= CD_A && ((t[0] - CD_A) % (2*CD_A)) == 0) begin
      j = t[0] / (2*CD_A);
      if (j >= 1) begin
        s = (j - 1) % 32;
        rx_sr = {rx_sr[30:0], sd_a};
`ifdef WTS_I2S_LJ_EN
        if (s == 31) begin
`else
        if (s == 0 && j >= 33) begin
`endif
          rx_word = rx_sr;
          rx_cnt++;
        end
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Stop right after instance A enters slot s.
  task automatic wait_slot(input int s);
    bit ok = 1'b0;
    for (int n = 0; n < 400; n++) begin
      step();
      if (t[0] > 0 && (t[0] % (2*CD_A)) == 0 && (((t[0] / (2*CD_A)) - 1) % 32) == s) begin
        ok = 1'b1;
        break;
      end
    end
    check($sformatf("wait_slot%0d", s), 32'(ok), 32'd1);
  endtask

  task automatic wait_rx(output logic [31:0] w);
    int c0 = rx_cnt;
    bit ok = 1'b0;
    for (int n = 0; n < 600; n++) begin
      step();
      if (rx_cnt != c0) begin
        ok = 1'b1;
        break;
      end
    end
    check("wait_rx", 32'(ok), 32'd1);
    w = rx_word;
  endtask

  // Count clk edges until instance A's frame_start is seen.
  task automatic cycles_to_fs(output int n);
    n = -1;
    for (int c = 1; c <= 600; c++) begin
      step();
      if (fs_a) begin
        n = c;
        break;
      end
    end
  endtask

  initial begin
    logic [31:0] w;
    int          n;
    cdv[0] = CD_A; cdv[1] = CD_B;
    for (int i = 0; i < 2; i++) begin
      t[i] = 0; cur[i] = '0; prev[i] = '0;
    end
    reset = 1'b1; enable = 1'b0; left_in = '0; right_in = '0;
    #1;
    check_all_zero("reset");
    run(2);
    reset = 1'b0;
    run(3);

    // Full-scale positive left, full-scale negative right.
    left_in = 12'h7FF; right_in = 12'h800; enable = 1'b1;
    wait_rx(w);
    check("i2s_word_7ff_800", w, 32'h7FF0_8000);
    cycles_to_fs(n);
    cycles_to_fs(n);
    check("fs_period", 32'(n), 32'(64*CD_A));

    // Arbitrary pattern, changed mid-frame so the first word is still old.
    wait_slot(5);
    left_in = 12'hA5C; right_in = 12'h123;
    wait_rx(w);
    wait_rx(w);
    check("word_a5c_123", w, 32'hA5C0_1230);

    // Inputs changed after capture must not touch the frame in flight.
    wait_slot(5);
    left_in = 12'h001;
    wait_rx(w);
    wait_slot(5);
    left_in = 12'hFFF;
    wait_rx(w);
    check("isolation_cur", 32'(w[31:16]), 32'h0010);
    wait_rx(w);
    check("isolation_next", 32'(w[31:16]), 32'hFFF0);

    // Abort mid-frame.
    wait_slot(20);
    enable = 1'b0;
    step();
    check("abort.bclk", 32'(bclk_a), 32'd0);
    check("abort.lr",   32'(lr_a),   32'd0);
    check("abort.sd",   32'(sd_a),   32'd0);
    check("abort.fs",   32'(fs_a),   32'd0);
    run(3);
    enable = 1'b1;
    cycles_to_fs(n);
    check("reenable_fs", 32'(n), 32'(2*CD_A));

    // Enable falls on the very edge that would capture: no frame_start.
    n = 0;
    for (int c = 0; c < 600; c++) begin
      if (t[0] > 0 && is_cap(CD_A, t[0] + 1)) begin
        n = 1;
        break;
      end
      step();
    end
    check("find_capture_edge", 32'(n), 32'd1);
    enable = 1'b0;
    step();
    check("idle_wins.fs", 32'(fs_a), 32'd0);
    enable = 1'b1;
    cycles_to_fs(n);
    check("after_idle_wins_fs", 32'(n), 32'(2*CD_A));

    // Asynchronous reset in the middle of a clk period.
    wait_slot(10);
    #2;
    reset = 1'b1;
    #1;
    check_all_zero("async_reset");
    run(2);
    reset = 1'b0;
    cycles_to_fs(n);
    check("reset_release_fs", 32'(n), 32'(2*CD_A));

    // Randomized run: random samples, random input change times, occasional
    // idle gaps and asynchronous resets.
    for (int seg = 0; seg < 60; seg++) begin
      left_in  = 12'($urandom);
      right_in = 12'($urandom);
      case ($urandom_range(0, 9))
        0: begin
          enable = 1'b0;
          run(int'($urandom_range(1, 5)));
          enable = 1'b1;
        end
        1: begin
          #2;
          reset = 1'b1;
          #1;
          check_all_zero("rand_async_reset");
          run(int'($urandom_range(1, 3)));
          reset = 1'b0;
        end
        default: ;
      endcase
      run(int'($urandom_range(1, 300)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
